// File: rtl/rx_fifo_ctrl.sv
// Receive-side controller: acknowledges each receiver byte once, buffers it in a
// first-word-fall-through FIFO, and reports overrun and character timeout.
module rx_fifo_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TOUT_TICKS = 160
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         rxav_i,
  input  logic [7:0]                   rxdata_i,
  output logic                         rxread_o,
  input  logic                         pop_i,
  output logic [7:0]                   data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         overrun_o,
  input  logic                         clr_ovr_i,
  output logic                         timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   TOUT_MAX = 16'(TOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   tcnt;

  logic          capture;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_n;
  logic [15:0]   tcnt_n;

  // Accept/reject decisions and next occupancy / timeout count
  always_comb begin
    capture = (state == S_IDLE) && rxav_i;
    pop_ok  = pop_i && !empty_o;
    push_ok = capture && (!full_o || pop_i);
    count_n = count_o;
    tcnt_n  = tcnt;
    if (push_ok && !pop_ok)
      count_n = count_o + CW'(1);
    else if (pop_ok && !push_ok)
      count_n = count_o - CW'(1);
    if (empty_o || push_ok || pop_ok)
      tcnt_n = 16'd0;
    else if (enable_i && (tcnt != TOUT_MAX))
      tcnt_n = tcnt + 16'd1;
  end

  // Handshake FSM: one push per receiver byte, WAIT holds until rxav drops
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      rxread_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rxav_i) begin
            state    <= S_ACK;
            rxread_o <= 1'b1;
          end
        end
        S_ACK: begin
          state    <= S_WAIT;
          rxread_o <= 1'b0;
        end
        S_WAIT: begin
          if (!rxav_i)
            state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          rxread_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_o   <= '0;
      empty_o   <= 1'b1;
      full_o    <= 1'b0;
      overrun_o <= 1'b0;
      tcnt      <= 16'd0;
      timeout_o <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_n;
      empty_o <= (count_n == '0);
      full_o  <= (count_n == FULL_CNT);
      // a drop in the same cycle as a clear keeps the flag set
      if (capture && !push_ok)
        overrun_o <= 1'b1;
      else if (clr_ovr_i)
        overrun_o <= 1'b0;
      tcnt      <= tcnt_n;
      timeout_o <= (tcnt_n == TOUT_MAX);
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (push_ok && !reset_i)
      mem[wr_ptr] <= rxdata_i;
  end

  assign data_o = mem[rd_ptr];

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Bench for rx_fifo_ctrl: hand-computed vector table, directed corner sequences,
// and randomized traffic checked against a queue-based model.
module tb_rx_fifo_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TOUT  = 8;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       rxav_i = 1'b0;
  logic [7:0] rxdata_i = 8'h00;
  logic       rxread_o;
  logic       pop_i = 1'b0;
  logic [7:0] data_o;
  logic       empty_o;
  logic       full_o;
  logic [4:0] count_o;
  logic       overrun_o;
  logic       clr_ovr_i = 1'b0;
  logic       timeout_o;

  rx_fifo_ctrl #(.DEPTH(DEPTH), .TOUT_TICKS(TOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .rxav_i(rxav_i),
    .rxdata_i(rxdata_i), .rxread_o(rxread_o), .pop_i(pop_i), .data_o(data_o),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: byte queue, handshake phase (0 ready, 1 acking, 2 awaiting release)
  logic [7:0] q[$];
  int         phase = 0;
  logic       m_rxread = 1'b0;
  logic       m_ovr = 1'b0;
  int         m_tcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit cap, pok, uok, was_empty;
    if (reset_i) begin
      q.delete();
      phase = 0; m_rxread = 1'b0; m_ovr = 1'b0; m_tcnt = 0;
    end else begin
      was_empty = (q.size() == 0);
      cap = (phase == 0) && rxav_i;
      pok = pop_i && (q.size() > 0);
      uok = cap && ((q.size() < DEPTH) || pop_i);
      if (pok) void'(q.pop_front());
      if (uok) q.push_back(rxdata_i);
      if (cap && !uok) m_ovr = 1'b1;
      else if (clr_ovr_i) m_ovr = 1'b0;
      if (was_empty || uok || pok) m_tcnt = 0;
      else if (enable_i && m_tcnt < TOUT) m_tcnt++;
      case (phase)
        0: phase = cap ? 1 : 0;
        1: phase = 2;
        default: phase = rxav_i ? 2 : 0;
      endcase
      m_rxread = (phase == 1);
    end
  endtask

  task automatic model_check();
    chk("m_rxread", 32'(rxread_o), 32'(m_rxread));
    chk("m_count", 32'(count_o), 32'(q.size()));
    chk("m_empty", 32'(empty_o), 32'(q.size() == 0));
    chk("m_full", 32'(full_o), 32'(q.size() == DEPTH));
    chk("m_overrun", 32'(overrun_o), 32'(m_ovr));
    chk("m_timeout", 32'(timeout_o), 32'(m_tcnt == TOUT));
    if (q.size() > 0) chk("m_head", 32'(data_o), 32'(q[0]));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    model_check();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxav_i = 1'b1; rxdata_i = b;
    cycle();
    rxav_i = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic tick(input string nm, input logic exp_tout);
    enable_i = 1'b1;
    cycle();
    enable_i = 1'b0;
    chk(nm, 32'(timeout_o), 32'(exp_tout));
    repeat (3) cycle();
  endtask

  typedef struct {
    logic       rst;
    logic       rxav;
    logic       pop;
    logic [7:0] din;
    logic       exp_rd;
    int         exp_cnt;
    logic       chk_d;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // single byte, held rxav, reset in the ACK cycle, recapture, pop on empty
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 1'b1, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 2, 1'b1, 8'hA5};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1, 1'b1, 8'h3C};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1, 1'b1, 8'h3C};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 8'h00};

    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 14; i++) begin
      reset_i = vecs[i].rst; rxav_i = vecs[i].rxav;
      pop_i = vecs[i].pop; rxdata_i = vecs[i].din;
      cycle();
      chk($sformatf("vec%0d_rxread", i), 32'(rxread_o), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vecs[i].exp_cnt == 0));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].exp_d));
    end
    pop_i = 1'b0; reset_i = 1'b0;
    chk("reset_overrun", 32'(overrun_o), 32'd0);

    // fill, partial drain and wrap
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd16);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_pop%0d", i), 32'(data_o), 32'(i));
      pop_i = 1'b1; cycle(); pop_i = 1'b0;
    end
    for (int i = 16; i < 20; i++) send_byte(8'(i));
    chk("wrap_count", 32'(count_o), 32'd16);

    // overrun while full, set beats clear, later clear
    rxav_i = 1'b1; rxdata_i = 8'h77;
    cycle();
    chk("ovr_rxread", 32'(rxread_o), 32'd1);
    chk("ovr_count", 32'(count_o), 32'd16);
    chk("ovr_flag", 32'(overrun_o), 32'd1);
    chk("ovr_head", 32'(data_o), 32'h04);
    rxav_i = 1'b0; cycle(); cycle();
    rxav_i = 1'b1; rxdata_i = 8'h78; clr_ovr_i = 1'b1;
    cycle();
    chk("ovr_set_wins", 32'(overrun_o), 32'd1);
    clr_ovr_i = 1'b0; rxav_i = 1'b0; cycle(); cycle();
    clr_ovr_i = 1'b1; cycle(); clr_ovr_i = 1'b0;
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // push and pop together while full
    rxav_i = 1'b1; rxdata_i = 8'h55; pop_i = 1'b1;
    cycle();
    chk("fpp_count", 32'(count_o), 32'd16);
    pop_i = 1'b0; rxav_i = 1'b0; cycle(); cycle();
    pop_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(data_o), (i < 15) ? 32'(5 + i) : 32'h55);
      cycle();
    end
    pop_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 32'd1);
    pop_i = 1'b1; cycle(); pop_i = 1'b0;
    chk("extra_pop_count", 32'(count_o), 32'd0);

    // character timeout
    send_byte(8'h99);
    for (int k = 1; k <= 8; k++) tick($sformatf("tout_tick%0d", k), k == 8);
    pop_i = 1'b1; cycle(); pop_i = 1'b0;
    chk("tout_clear", 32'(timeout_o), 32'd0);
    chk("tout_empty", 32'(empty_o), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 1; k <= 5; k++) tick($sformatf("rst_tick%0d", k), 1'b0);
    pop_i = 1'b1; cycle(); pop_i = 1'b0;
    for (int k = 1; k <= 8; k++) tick($sformatf("restart_tick%0d", k), k == 8);
    pop_i = 1'b1; cycle(); pop_i = 1'b0;
    chk("restart_clear", 32'(timeout_o), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset_i  = ($urandom_range(299) == 0);
      enable_i = ($urandom_range(3) == 0);
      pop_i    = ($urandom_range(99) < 30);
      clr_ovr_i = ($urandom_range(19) == 0);
      if (!rxav_i) begin
        rxdata_i = 8'($urandom);
        rxav_i = ($urandom_range(99) < 40);
      end else begin
        rxav_i = ($urandom_range(99) < 60);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
